// File: rtl/pe_psum_accumulator.sv
// Partial-sum accumulation stage: joins the local psum stream with the inbound
// upstream psum, saturates to DATA_W bits, and drives a one-entry output register.
module pe_psum_accumulator #(
  parameter int DATA_W = 21,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              local_valid,
  output logic              local_ready,
  input  logic [DATA_W-1:0] local_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Signed add with one guard bit; clamp when the guard and sign bits disagree.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat_add = sum[DATA_W] ? DATA_MIN : DATA_MAX;
    end else begin
      sat_add = sum[DATA_W-1:0];
    end
  endfunction

  logic [1:0]        state_r;
  logic              mode_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  acc_cnt_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              done_r;

  logic              run_s;
  logic              slot_free_s;
  logic              fire_s;
  logic              last_s;
  logic              local_ready_s;
  logic              in_ready_s;
  logic [DATA_W-1:0] result_s;

  assign run_s       = (state_r == ST_RUN);
  assign slot_free_s = ~out_valid_r | out_ready;
  assign last_s      = ((acc_cnt_r + CNT_ONE) == count_r);

  // Accept decision and input readies; in join mode both streams move together.
  always_comb begin
    local_ready_s = 1'b0;
    in_ready_s    = 1'b0;
    fire_s        = 1'b0;
    result_s      = local_data;
    if (mode_r) begin
      local_ready_s = run_s & slot_free_s & in_valid;
      in_ready_s    = run_s & slot_free_s & local_valid;
      fire_s        = run_s & slot_free_s & local_valid & in_valid;
      result_s      = sat_add(local_data, in_data);
    end else begin
      local_ready_s = run_s & slot_free_s;
      in_ready_s    = 1'b0;
      fire_s        = run_s & slot_free_s & local_valid;
      result_s      = local_data;
    end
  end

  // Control FSM, pass counter and the single-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= 1'b0;
      count_r     <= CNT_ZERO;
      acc_cnt_r   <= CNT_ZERO;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (fire_s) begin
        out_data_r  <= result_s;
        out_valid_r <= 1'b1;
        acc_cnt_r   <= acc_cnt_r + CNT_ONE;
      end else if (out_valid_r & out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_count != CNT_ZERO) begin
              state_r   <= ST_RUN;
              mode_r    <= cfg_mode;
              count_r   <= cfg_count;
              acc_cnt_r <= CNT_ZERO;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (fire_s & last_s) begin
            state_r <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (slot_free_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign local_ready = local_ready_s;
  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign busy        = (state_r != ST_IDLE);
  assign done        = done_r;

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Directed bench for pe_psum_accumulator: hand-computed psum vectors checked
// through an output scoreboard plus cycle-level checks of readies, busy and done.
module tb_pe_psum_accumulator;

  localparam int DATA_W = 21;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic              cfg_start;
  logic              cfg_mode;
  logic [CNT_W-1:0]  cfg_count;
  logic              local_valid;
  logic              local_ready;
  logic [DATA_W-1:0] local_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  pe_psum_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_count(cfg_count),
    .local_valid(local_valid), .local_ready(local_ready), .local_data(local_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int out_cnt = 0;
  int exp_q[$];
  int fire_q[$];
  int tb_mode = 0;
  bit lat_chk = 1'b0;
  bit have_last_fire = 1'b0;
  int last_fire = 0;
  bit in_rdy_seen = 1'b0;
  bit lf, inf;
  int fcyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Output scoreboard, join/latency observation and done counting.
  always @(negedge clk) begin
    if (rst) begin
      fire_q.delete();
    end else begin
      lf  = local_valid & local_ready;
      inf = in_valid & in_ready;
      if (tb_mode == 1 && (lf || inf)) check_val("join", int'(lf), int'(inf));
      if (tb_mode == 0 && in_ready) in_rdy_seen = 1'b1;
      if (lf) begin
        if (lat_chk && have_last_fire) check_val("fire_gap", cyc - last_fire, 1);
        last_fire = cyc;
        have_last_fire = 1'b1;
        fire_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check_val("out_extra", int'($signed(out_data)), 0 - 9999999);
        else check_val("out_data", int'($signed(out_data)), exp_q.pop_front());
        if (fire_q.size() != 0) begin
          fcyc = fire_q.pop_front();
          if (lat_chk) check_val("latency", cyc - fcyc, 1);
        end
      end
      if (done) begin
        done_cnt++;
        check_val("done_busy", int'(busy), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int mode, input int count);
    tb_mode   = mode;
    cfg_mode  = mode[0];
    cfg_count = count[CNT_W-1:0];
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    if (count != 0) check_val("busy_rise", int'(busy), 1);
  endtask

  task automatic send_local(input int d, input int gap);
    bit hs;
    int n;
    repeat (gap) tick();
    local_valid = 1'b1;
    local_data  = d[DATA_W-1:0];
    hs = 1'b0;
    n = 0;
    while (!hs && n < 1000) begin
      @(negedge clk);
      hs = local_ready;
      tick();
      n++;
    end
    if (!hs) check_val("local_timeout", 0, 1);
    local_valid = 1'b0;
  endtask

  task automatic send_in(input int d, input int gap);
    bit hs;
    int n;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d[DATA_W-1:0];
    hs = 1'b0;
    n = 0;
    while (!hs && n < 1000) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      n++;
    end
    if (!hs) check_val("in_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, int'(done), 1);
    tick();
    check_val({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  int d0, o0, n;
  int loc_v[4];
  int in_v[4];
  int res_v[4];

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_count = '0;
    local_valid = 1'b1; local_data = '0; in_valid = 1'b1; in_data = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_out_data", int'(out_data), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_local_ready", int'(local_ready), 0);
    check_val("rst_in_ready", int'(in_ready), 0);
    local_valid = 1'b0; in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Mode 0 pass-through, full rate.
    d0 = done_cnt; in_rdy_seen = 1'b0; have_last_fire = 1'b0; lat_chk = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(i);
    start_pass(0, 4);
    for (int i = 1; i <= 4; i++) send_local(i, 0);
    wait_done("m0_done");
    lat_chk = 1'b0;
    check_val("m0_in_ready_low", int'(in_rdy_seen), 0);
    tick();
    check_val("m0_done_once", done_cnt - d0, 1);

    // Mode 1 join with the inbound stream lagging.
    d0 = done_cnt;
    exp_q.push_back(15); exp_q.push_back(-5); exp_q.push_back(37);
    start_pass(1, 3);
    fork
      begin send_local(10, 0); send_local(20, 0); send_local(30, 0); end
      begin send_in(5, 2); send_in(-25, 2); send_in(7, 2); end
    join
    wait_done("skew_done");
    check_val("skew_done_once", done_cnt - d0, 1);

    // Saturation corners.
    loc_v = '{1048575, -1048576, 600000, -3};
    in_v  = '{1, -1, 600000, 2};
    res_v = '{1048575, -1048576, 1048575, -1};
    for (int i = 0; i < 4; i++) exp_q.push_back(res_v[i]);
    start_pass(1, 4);
    fork
      begin for (int i = 0; i < 4; i++) send_local(loc_v[i], 0); end
      begin for (int j = 0; j < 4; j++) send_in(in_v[j], 0); end
    join
    wait_done("sat_done");

    // Backpressure: hold out_ready low for 5 cycles with both inputs valid.
    exp_q.push_back(101); exp_q.push_back(202); exp_q.push_back(303);
    out_ready = 1'b0;
    start_pass(1, 3);
    fork
      begin send_local(100, 0); send_local(200, 0); send_local(300, 0); end
      begin send_in(1, 0); send_in(2, 0); send_in(3, 0); end
      begin
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check_val("bp_first_valid", int'(out_valid), 1);
        repeat (5) begin
          @(negedge clk);
          check_val("bp_data_hold", int'($signed(out_data)), 101);
          check_val("bp_local_ready", int'(local_ready), 0);
          check_val("bp_in_ready", int'(in_ready), 0);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    wait_done("bp_done");

    // Zero-length pass.
    d0 = done_cnt;
    start_pass(0, 0);
    check_val("zero_done", int'(done), 1);
    check_val("zero_busy", int'(busy), 0);
    tick();
    check_val("zero_done_pulse", int'(done), 0);
    check_val("zero_done_once", done_cnt - d0, 1);

    // cfg_start while running must not disturb the pass.
    d0 = done_cnt;
    exp_q.push_back(7); exp_q.push_back(8);
    start_pass(0, 2);
    cfg_start = 1'b1; cfg_mode = 1'b1; cfg_count = 8'd0;
    tick();
    cfg_start = 1'b0;
    check_val("ign_busy", int'(busy), 1);
    check_val("ign_done", int'(done), 0);
    send_local(7, 0);
    send_local(8, 0);
    wait_done("ign_pass_done");
    check_val("ign_done_once", done_cnt - d0, 1);

    // Maximum-length pass.
    d0 = done_cnt; o0 = out_cnt;
    for (int i = 0; i < 255; i++) exp_q.push_back(i * 4099 - 500000);
    start_pass(0, 255);
    for (int i = 0; i < 255; i++) send_local(i * 4099 - 500000, 0);
    wait_done("max_done");
    check_val("max_out_count", out_cnt - o0, 255);
    check_val("max_done_once", done_cnt - d0, 1);

    // Reset mid-pass with a result held in the output register.
    d0 = done_cnt;
    exp_q.push_back(11);
    start_pass(0, 4);
    send_local(11, 0);
    send_local(12, 0);
    check_val("mid_pre_valid", int'(out_valid), 1);
    rst = 1'b1; out_ready = 1'b0;
    tick();
    check_val("mid_out_valid", int'(out_valid), 0);
    check_val("mid_busy", int'(busy), 0);
    check_val("mid_done", int'(done), 0);
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check_val("mid_no_done", done_cnt - d0, 0);
    check_val("mid_qempty", exp_q.size(), 0);

    // A fresh pass after the reset.
    d0 = done_cnt;
    exp_q.push_back(2); exp_q.push_back(4);
    start_pass(1, 2);
    fork
      begin send_local(1, 0); send_local(2, 0); end
      begin send_in(1, 1); send_in(2, 0); end
    join
    wait_done("post_rst_done");
    check_val("post_rst_done_once", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pe_psum_accumulator.md
# pe_psum_accumulator

Per-PE partial-sum accumulation stage that sits directly upstream of the PE psum output FIFO. It joins the locally computed psum stream from the PE MAC/psum scratchpad with the inbound psum stream arriving from the upstream PE (via the psum input FIFO), adds them with 21-bit saturation, and presents the result to the psum output FIFO through a registered valid/ready port. A small control FSM counts a configured number of psums per pass and pulses `done` once the last result has left the block.

## Interface
- `DATA_W`, 21: psum width, signed two's complement.
- `CNT_W`, 8: width of the per-pass psum count.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_start`  in  1  starts a pass; sampled only in IDLE.
- `cfg_mode`  in  1  0 = pass local psum only; 1 = local + inbound. Latched on `cfg_start`.
- `cfg_count`  in  CNT_W  number of psums in the pass. Latched on `cfg_start`.
- `local_valid` / `local_ready`  in / out  1  handshake for the local psum stream.
- `local_data`  in  DATA_W  local psum.
- `in_valid` / `in_ready`  in / out  1  handshake for the inbound psum stream from the upstream PE.
- `in_data`  in  DATA_W  inbound psum.
- `out_valid` / `out_ready`  out / in  1  handshake to the psum output FIFO.
- `out_data`  out  DATA_W  accumulated psum.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse marking the end of a pass.

## Operation
- **FSM states:** IDLE, RUN, FLUSH.
  - IDLE → RUN on `cfg_start` with `cfg_count` ≠ 0. This latches `mode_r` and `count_r`, and clears the accepted-element counter `acc_cnt`.
  - IDLE with `cfg_start` and `cfg_count` = 0: `done` pulses on the next cycle and the FSM stays in IDLE.
  - RUN → FLUSH on the cycle the `count_r`-th element is accepted.
  - FLUSH → IDLE on the cycle the output register is empty, or is being emptied by an output handshake. `done` pulses on that transition.
- `cfg_start` while `busy` is ignored. `cfg_*` values are used only at start.
- **Output register:** holds `out_data` and `out_valid`. Define `slot_free = ~out_valid | out_ready`.
- **Accept condition (`fire`):**
  - Mode 0: `fire = RUN & slot_free & local_valid`. `local_ready = RUN & slot_free`. `in_ready` = 0; the inbound stream is never consumed.
  - Mode 1 (join): `fire = RUN & slot_free & local_valid & in_valid`. `local_ready = RUN & slot_free & in_valid`. `in_ready = RUN & slot_free & local_valid`. Both streams are consumed in the same cycle or neither is.
  - The readies may depend combinationally on the opposite valid. Valids must not depend on readies.
- **Arithmetic:**
  - Mode 0: the result is `local_data` unchanged.
  - Mode 1: the (DATA_W+1)-bit signed sum of both inputs, saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. [−1048576, 1048575] at the default width.
- **On `fire`:** the output register loads the result and `out_valid` is set to 1. `acc_cnt` increments.
- **Output handshake without `fire`:** `out_valid` clears.
- Outside RUN, `local_ready` and `in_ready` are 0.

## Timing
- **Reset values:** state = IDLE, `out_valid` = 0, `out_data` = 0, `done` = 0, `busy` = 0, `acc_cnt` = 0, `local_ready` = 0, `in_ready` = 0.
- **Reset mid-pass:** any held result is discarded and there is no `done` pulse.
- **Latency:** 1 cycle from `fire` to `out_valid`.
- **Throughput:** 1 psum per cycle while `out_ready` stays high, including back-to-back accept and drain in the same cycle.
- **Backpressure:** when `out_ready` = 0 with `out_valid` = 1, `out_data` is held stable and both input readies drop in the same cycle. There is no internal storage beyond one entry.
- **Counter:** `acc_cnt` is CNT_W bits wide and never wraps within a pass, because the maximum pass length is 2^CNT_W−1.
- **`busy` and `done`:**
  - `busy` rises the cycle after `cfg_start` and falls the cycle after the last output handshake.
  - `done` asserts in the same cycle `busy` falls.
  - If the final element's output is accepted in the cycle immediately after `fire`, the FSM spends exactly one cycle in FLUSH.

## Test plan
- **Mode 0 pass-through:** `cfg_count` = 4, local data 1, 2, 3, 4, `out_ready` always 1 → outputs 1, 2, 3, 4 on consecutive cycles, each 1 cycle after its accept; `in_ready` stays 0; a single `done` pulse after the 4th output.
- **Mode 1 join skew:** `cfg_count` = 3, local 10/20/30 presented early, inbound 5/−25/7 delayed 2 cycles each → outputs 15, −5, 37; no element is consumed from either stream without its partner.
- **Saturation:**
  - 1048575 + 1 → 1048575.
  - −1048576 + (−1) → −1048576.
  - 600000 + 600000 → 1048575.
  - −3 + 2 → −1.
- **Backpressure:** `out_ready` held 0 for 5 cycles with both inputs valid → `out_data` stable, `local_ready` and `in_ready` = 0, no lost or duplicated element after release.
- **Boundaries:**
  - `cfg_count` = 0 → `done` one cycle later, `busy` stays 0.
  - `cfg_start` during RUN is ignored.
  - `cfg_count` = 255 completes with exactly 255 outputs.
- **Reset mid-pass:** `rst` after 2 of 4 accepts with `out_valid` = 1 → next cycle `out_valid` = 0, state IDLE, no `done`; a new pass then runs correctly.
